// File: rtl/ps2_key_receiver_if.sv
// rtl/ps2_key_receiver_if.sv - read handshake and status between the UC/IO path and the key receiver.
interface ps2_key_if;
  logic        FLAG_input;
  logic [31:0] IO_key;
  logic        done;
  logic        empty;
  logic        overflow;
  logic        frame_error;

  modport master (
    output FLAG_input,
    input  IO_key, done, empty, overflow, frame_error
  );

  modport slave (
    input  FLAG_input,
    output IO_key, done, empty, overflow, frame_error
  );
endinterface

// File: rtl/ps2_key_receiver.sv
// rtl/ps2_key_receiver.sv - PS/2 device-to-host frame receiver with make/break filter,
// scan-code FIFO and one-code-per-request read handshake.
module ps2_key_receiver #(
  parameter int TIMEOUT_WIDTH = 16,
  parameter int FIFO_AWIDTH   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  ps2_key_if.slave   key_if
);

  localparam int DEPTH = 1 << FIFO_AWIDTH;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  logic ps2c_s1_q, ps2c_s2_q, ps2c_prev_q;
  logic ps2d_s1_q, ps2d_s2_q;
  logic fall, bit_in;

  state_e                   state_q, state_d;
  logic [2:0]               bitcnt_q, bitcnt_d;
  logic [7:0]               shift_q, shift_d;
  logic                     parity_q, parity_d;
  logic [TIMEOUT_WIDTH-1:0] wdog_q, wdog_d;
  logic                     byte_ok, frame_err;

  logic break_q;
  logic push_req, push, pop, drop;

  logic [7:0]           mem_q [DEPTH];
  logic [FIFO_AWIDTH:0] wr_ptr_q, rd_ptr_q;
  logic                 fifo_empty, fifo_full;

  logic        flag_prev_q, armed_q, armed, armed_d;
  logic [31:0] io_key_q;
  logic        done_q, overflow_q, frame_error_q;

  // ps2_clk idles high, so the sync chain resets high to avoid a phantom edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2c_s1_q   <= 1'b1;
      ps2c_s2_q   <= 1'b1;
      ps2c_prev_q <= 1'b1;
      ps2d_s1_q   <= 1'b1;
      ps2d_s2_q   <= 1'b1;
    end else begin
      ps2c_s1_q   <= ps2_clk;
      ps2c_s2_q   <= ps2c_s1_q;
      ps2c_prev_q <= ps2c_s2_q;
      ps2d_s1_q   <= ps2_data;
      ps2d_s2_q   <= ps2d_s1_q;
    end
  end

  assign fall   = ps2c_prev_q & ~ps2c_s2_q;
  assign bit_in = ps2d_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      wdog_q   <= wdog_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    wdog_d    = '0;
    byte_ok   = 1'b0;
    frame_err = 1'b0;
    if (state_q != S_IDLE) begin
      wdog_d = wdog_q + TIMEOUT_WIDTH'(1);
    end
    if (fall) begin
      wdog_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!bit_in) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
            shift_d  = '0;
          end else begin
            frame_err = 1'b1;
          end
        end
        S_DATA: begin
          shift_d  = {bit_in, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = bit_in;
          state_d  = S_STOP;
        end
        S_STOP: begin
          if (bit_in && ((^shift_q) ^ parity_q)) byte_ok = 1'b1;
          else                                   frame_err = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if ((state_q != S_IDLE) && (&wdog_q)) begin
      frame_err = 1'b1;
      state_d   = S_IDLE;
      wdog_d    = '0;
    end
  end

  // The E0 prefix needs no state: the extended key's second byte is pushed bare.
  assign push_req = byte_ok && (shift_q != 8'hE0) && (shift_q != 8'hF0) && !break_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      break_q <= 1'b0;
    end else if (byte_ok && (shift_q != 8'hE0)) begin
      break_q <= (shift_q == 8'hF0);
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AWIDTH] != rd_ptr_q[FIFO_AWIDTH]) &&
                      (wr_ptr_q[FIFO_AWIDTH-1:0] == rd_ptr_q[FIFO_AWIDTH-1:0]);

  assign armed   = (armed_q | (key_if.FLAG_input & ~flag_prev_q)) & key_if.FLAG_input;
  assign pop     = armed & ~fifo_empty;
  assign armed_d = armed & ~pop;
  assign push    = push_req & (~fifo_full | pop);
  assign drop    = push_req & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[FIFO_AWIDTH-1:0]] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      flag_prev_q   <= 1'b0;
      armed_q       <= 1'b0;
      io_key_q      <= '0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        io_key_q <= {24'b0, mem_q[rd_ptr_q[FIFO_AWIDTH-1:0]]};
      end
      flag_prev_q   <= key_if.FLAG_input;
      armed_q       <= armed_d;
      done_q        <= pop;
      overflow_q    <= overflow_q | drop;
      frame_error_q <= frame_err;
    end
  end

  assign key_if.IO_key      = io_key_q;
  assign key_if.done        = done_q;
  assign key_if.empty       = fifo_empty;
  assign key_if.overflow    = overflow_q;
  assign key_if.frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb/tb_ps2_key_receiver.sv - directed bench for ps2_key_receiver.
module tb_ps2_key_receiver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int fe_cnt = 0;
  logic empty_prev = 1'b1;
  logic done_prev_empty = 1'b1;

  ps2_key_if key_if ();

  ps2_key_receiver dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_if   (key_if)
  );

  always #10 clk = ~clk;

  initial begin
    #1900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (key_if.done) begin
      done_cnt = done_cnt + 1;
      done_prev_empty = empty_prev;
    end
    if (key_if.frame_error) fe_cnt = fe_cnt + 1;
    empty_prev = key_if.empty;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clk(3);
    ps2_clk = 1'b0;
    wait_clk(6);
    ps2_clk = 1'b1;
    wait_clk(3);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    wait_clk(5);
  endtask

  task automatic do_read(input logic [7:0] exp, input string tag);
    int d0;
    d0 = done_cnt;
    key_if.FLAG_input = 1'b1;
    @(negedge clk);
    check_eq({tag, "_done"}, {31'b0, key_if.done}, 32'd1);
    check_eq({tag, "_key"}, key_if.IO_key, {24'b0, exp});
    wait_clk(4);
    check_eq({tag, "_once"}, done_cnt - d0, 32'd1);
    key_if.FLAG_input = 1'b0;
    wait_clk(2);
  endtask

  initial begin
    int d0;
    int f0;
    key_if.FLAG_input = 1'b0;
    do_reset();

    check_eq("rst_key", key_if.IO_key, 32'h0);
    check_eq("rst_done", {31'b0, key_if.done}, 32'd0);
    check_eq("rst_empty", {31'b0, key_if.empty}, 32'd1);
    check_eq("rst_ovf", {31'b0, key_if.overflow}, 32'd0);
    check_eq("rst_ferr", {31'b0, key_if.frame_error}, 32'd0);

    send_frame(8'h1C, 1'b0);
    check_eq("t1_notempty", {31'b0, key_if.empty}, 32'd0);
    do_read(8'h1C, "t1");
    check_eq("t1_empty", {31'b0, key_if.empty}, 32'd1);
    check_eq("t1_no_ferr", fe_cnt, 32'd0);

    send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    do_read(8'h1C, "t2a");
    d0 = done_cnt;
    key_if.FLAG_input = 1'b1;
    wait_clk(50);
    check_eq("t2b_nodone", done_cnt - d0, 32'd0);
    check_eq("t2b_empty", {31'b0, key_if.empty}, 32'd1);
    key_if.FLAG_input = 1'b0;
    wait_clk(2);

    f0 = fe_cnt;
    send_frame(8'h1C, 1'b1);
    check_eq("t3_ferr", fe_cnt - f0, 32'd1);
    check_eq("t3_empty", {31'b0, key_if.empty}, 32'd1);
    send_frame(8'h32, 1'b0);
    do_read(8'h32, "t3");

    f0 = fe_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_data = 1'b1;
    wait_clk(65000);
    check_eq("t4_no_early_ferr", fe_cnt - f0, 32'd0);
    wait_clk(600);
    check_eq("t4_timeout_ferr", fe_cnt - f0, 32'd1);
    send_frame(8'h1C, 1'b0);
    check_eq("t4_after_ferr", fe_cnt - f0, 32'd1);
    do_read(8'h1C, "t4");

    for (int i = 0; i < 9; i++) send_frame(8'h15 + 8'(i), 1'b0);
    check_eq("t5_ovf", {31'b0, key_if.overflow}, 32'd1);
    for (int i = 0; i < 8; i++) do_read(8'h15 + 8'(i), $sformatf("t5_rd%0d", i));
    check_eq("t5_empty", {31'b0, key_if.empty}, 32'd1);
    check_eq("t5_ovf_sticky", {31'b0, key_if.overflow}, 32'd1);
    do_reset();
    check_eq("t5_ovf_rst", {31'b0, key_if.overflow}, 32'd0);

    d0 = done_cnt;
    key_if.FLAG_input = 1'b1;
    wait_clk(5);
    send_frame(8'hE0, 1'b0);
    check_eq("t6_e0_filtered", done_cnt - d0, 32'd0);
    send_frame(8'h75, 1'b0);
    check_eq("t6_done", done_cnt - d0, 32'd1);
    check_eq("t6_key", key_if.IO_key, 32'h75);
    check_eq("t6_lat1", {31'b0, done_prev_empty}, 32'd0);
    check_eq("t6_empty", {31'b0, key_if.empty}, 32'd1);
    wait_clk(100);
    check_eq("t6_hold", done_cnt - d0, 32'd1);
    key_if.FLAG_input = 1'b0;
    wait_clk(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
